img_frame_writer: RTL and testbench
===================================

// Module: img_frame_writer
// PURPOSE
//  Write-side counterpart of the blur path's image reader. Accepts a top-down raster RGB pixel stream
//  via valid/ready and stores it as interleaved 8-bit R,G,B bytes in a byte-wide frame memory.
//  Row order is bottom-up, matching the hex image dump format: row 0 goes to the highest row slot.
//  Sits between the filter datapath and the output frame buffer / hex dump memory.
// PARAMETERS
//  WIDTH   256  pixels per row (>=2)
//  HEIGHT  256  rows per frame (>=1)
//  ADDR_W  $clog2(WIDTH*HEIGHT*3)  localparam; byte address width (18 at defaults)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       synchronous, active-low reset
//  start      in   1       1-cycle pulse, arms a new frame; ignored unless idle
//  s_valid    in   1       pixel valid
//  s_ready    out  1       writer can take a pixel
//  s_data     in   24      {R[23:16],G[15:8],B[7:0]}
//  mem_we     out  1       byte write strobe
//  mem_addr   out  ADDR_W  byte address
//  mem_wdata  out  8       byte data
//  busy       out  1       high from accepted start until done
//  done       out  1       1-cycle pulse after last byte written
// BEHAVIOUR
//  - Reset: every output is 0 (s_ready, mem_we, mem_addr, mem_wdata, busy, done, err); FSM goes to IDLE; counters cleared.
//  - FSM: IDLE -start-> ACCEPT; ACCEPT -(s_valid&s_ready)-> WR_R -> WR_G -> WR_B;
//    WR_B -> ACCEPT if not last pixel, else DONE; DONE -> IDLE.
//  - s_ready=1 only in ACCEPT. Handshake captures s_data into pix reg. One pixel per 4 cycles max.
//  - mem_we=1 exactly in WR_R/WR_G/WR_B. Bytes are written in that order, one per cycle, taken from the captured pix.
//  - Address: base = WIDTH*3*(HEIGHT-1-row) + 3*col. The R, G and B bytes go to base+0, base+1, base+2.
//    Computed incrementally, no multiplier:
//    * row_base starts at WIDTH*3*(HEIGHT-1).
//    * col_off advances by 3 per pixel.
//    * At col==WIDTH-1: col_off resets to 0, row_base drops by WIDTH*3, row increments.
//  - Last pixel = row HEIGHT-1, col WIDTH-1 (bytes at 3*(WIDTH-1)+0..2).
//  - done=1 for one cycle in DONE. busy=1 in ACCEPT..DONE inclusive.
//  - start while busy: ignored. start in same cycle as rst_n=0: reset wins.
//  - s_valid high before start: no handshake until ACCEPT is entered (s_ready is low in IDLE).
//  - s_valid dropping in ACCEPT: wait indefinitely. s_data need not be held after handshake.
//  - Reset mid-frame: partial frame abandoned, no done pulse, counters cleared.
// CONFIGURATION
//  Macro IMG_WR_SYNC_CHECK_EN.
//  Defined:
//   - Adds ports s_sof (in 1), s_eol (in 1) and err (out 1).
//   - At each handshake, s_sof must equal (row==0 && col==0) and s_eol must equal (col==WIDTH-1).
//   - A mismatch sets err; err is sticky until the next accepted start or reset.
//   - The pixel is still written and the FSM is unaffected.
//  Undefined: these ports and the check logic are absent. Behaviour is otherwise identical.
// STRUCTURE
//  Package img_pkg:
//   - PIX_W=24
//   - typedef struct packed {logic [7:0] r,g,b;} rgb_t
//   - typedef enum {IDLE,ACCEPT,WR_R,WR_G,WR_B,DONE} wr_state_t
//  Sub-module img_addr_gen: row/col counters, row_base/col_off regs, last-pixel flag.
//  Interface: step input, base address output.
// TESTING  (bench uses WIDTH=4, HEIGHT=2 unless noted)
//  1. Reset, then start; s_data=24'hAABBCC held valid.
//     -> first writes: addr 12=AA, 13=BB, 14=CC on consecutive cycles; s_ready low during them.
//  2. Full frame of 8 pixels, pixel k = {k,k+8'h10,k+8'h20}.
//     -> pixel 0 at bytes 12..14, pixel 3 at 21..23, pixel 4 at 0..2, pixel 7 at 9..11.
//     -> done pulses exactly one cycle after the write to addr 11; busy then falls.
//  3. s_valid toggled randomly.
//     -> no duplicate or lost pixels; all 24 bytes match the expected image in a memory model.
//  4. start pulsed while busy mid-frame -> ignored; frame completes normally with a single done.
//  5. rst_n=0 after pixel 2; then start a new frame.
//     -> outputs 0 and no done from the aborted frame; new frame begins again at addr 12.
//  6. (IMG_WR_SYNC_CHECK_EN) s_eol asserted on pixel 2 (col 2).
//     -> err rises after that handshake, stays high through done, clears on next start.

Source files
------------

// File: rtl/img_frame_writer_pkg.sv
// rtl/img_frame_writer_pkg.sv - shared types for the frame writer
package img_pkg;

    localparam int PIX_W = 24;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WR_R,
        WR_G,
        WR_B,
        DONE
    } wr_state_t;

endpackage

// File: rtl/img_frame_writer_if.sv
// rtl/img_frame_writer_if.sv - pixel stream in, byte-wide frame memory out (IMG_WR_SYNC_CHECK_EN adds sof/eol)
interface img_frame_writer_if #(
    parameter int ADDR_W = 18
);
    logic              s_valid;
    logic              s_ready;
    logic [23:0]       s_data;
`ifdef IMG_WR_SYNC_CHECK_EN
    logic              s_sof;
    logic              s_eol;
`endif
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

`ifdef IMG_WR_SYNC_CHECK_EN
    modport slave  (input  s_valid, s_data, s_sof, s_eol,
                    output s_ready, mem_we, mem_addr, mem_wdata);
    modport master (output s_valid, s_data, s_sof, s_eol,
                    input  s_ready, mem_we, mem_addr, mem_wdata);
`else
    modport slave  (input  s_valid, s_data,
                    output s_ready, mem_we, mem_addr, mem_wdata);
    modport master (output s_valid, s_data,
                    input  s_ready, mem_we, mem_addr, mem_wdata);
`endif
endinterface

// File: rtl/img_frame_writer_addr_gen.sv
// rtl/img_frame_writer_addr_gen.sv - bottom-up raster byte address, built incrementally (IMG_WR_SYNC_CHECK_EN adds first/eol flags)
module img_addr_gen #(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256,
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] base_o,
    output logic              last_o
`ifdef IMG_WR_SYNC_CHECK_EN
    ,
    output logic              first_o,
    output logic              eol_o
`endif
);
    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(WIDTH * 3);
    localparam logic [ADDR_W-1:0] TOP_BASE   = ADDR_W'(WIDTH * 3 * (HEIGHT - 1));

    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [ADDR_W-1:0] row_base_q;
    logic [ADDR_W-1:0] col_off_q;
    logic              eol;

    assign eol    = (col_q == COL_W'(WIDTH - 1));
    assign base_o = row_base_q + col_off_q;
    assign last_o = eol && (row_q == ROW_W'(HEIGHT - 1));
`ifdef IMG_WR_SYNC_CHECK_EN
    assign first_o = (col_q == '0) && (row_q == '0);
    assign eol_o   = eol;
`endif

    // Row 0 lands in the top slot; each completed row moves one stride down.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= TOP_BASE;
            col_off_q  <= '0;
        end else if (step_i) begin
            if (eol) begin
                col_q      <= '0;
                col_off_q  <= '0;
                row_q      <= row_q + 1'b1;
                row_base_q <= row_base_q - ROW_STRIDE;
            end else begin
                col_q     <= col_q + 1'b1;
                col_off_q <= col_off_q + ADDR_W'(3);
            end
        end
    end

endmodule

// File: rtl/img_frame_writer.sv
// rtl/img_frame_writer.sv - raster RGB stream to bottom-up interleaved byte frame (IMG_WR_SYNC_CHECK_EN adds err)
module img_frame_writer
    import img_pkg::*;
#(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    img_frame_writer_if.slave   bus,
    output logic                busy,
    output logic                done
`ifdef IMG_WR_SYNC_CHECK_EN
    ,
    output logic                err
`endif
);
    localparam int ADDR_W = $clog2(WIDTH * HEIGHT * 3);

    wr_state_t         state_q;
    rgb_t              pix_in;
    logic [15:0]       pix_gb_q;
    logic              s_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              busy_q;
    logic              done_q;
    logic              hs;
    logic              start_ok;
    logic              last_pix;
    logic [ADDR_W-1:0] base;
`ifdef IMG_WR_SYNC_CHECK_EN
    logic              err_q;
    logic              first_pix;
    logic              eol_pix;
`endif

    assign pix_in   = rgb_t'(bus.s_data);
    assign hs       = (state_q == ACCEPT) && s_ready_q && bus.s_valid;
    assign start_ok = (state_q == IDLE) && start;

    img_addr_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (start_ok),
        .step_i  (state_q == WR_B),
        .base_o  (base),
        .last_o  (last_pix)
`ifdef IMG_WR_SYNC_CHECK_EN
        ,
        .first_o (first_pix),
        .eol_o   (eol_pix)
`endif
    );

    // Outputs are loaded on the transition into each state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pix_gb_q    <= '0;
            s_ready_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef IMG_WR_SYNC_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= ACCEPT;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
`ifdef IMG_WR_SYNC_CHECK_EN
                        err_q     <= 1'b0;
`endif
                    end
                end
                ACCEPT: begin
                    if (hs) begin
                        state_q     <= WR_R;
                        s_ready_q   <= 1'b0;
                        pix_gb_q    <= {pix_in.g, pix_in.b};
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= base;
                        mem_wdata_q <= pix_in.r;
`ifdef IMG_WR_SYNC_CHECK_EN
                        if ((bus.s_sof != first_pix) || (bus.s_eol != eol_pix))
                            err_q <= 1'b1;
`endif
                    end
                end
                WR_R: begin
                    state_q     <= WR_G;
                    mem_addr_q  <= mem_addr_q + 1'b1;
                    mem_wdata_q <= pix_gb_q[15:8];
                end
                WR_G: begin
                    state_q     <= WR_B;
                    mem_addr_q  <= mem_addr_q + 1'b1;
                    mem_wdata_q <= pix_gb_q[7:0];
                end
                WR_B: begin
                    mem_we_q <= 1'b0;
                    if (last_pix) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q   <= ACCEPT;
                        s_ready_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    s_ready_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
`ifdef IMG_WR_SYNC_CHECK_EN
    assign err           = err_q;
`endif

endmodule

// File: tb/tb_img_frame_writer.sv
// tb/tb_img_frame_writer.sv - randomized frame writer bench against a raster-to-bottom-up memory model
module tb_img_frame_writer;
    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;
    localparam int NB   = NPIX * 3;
    localparam int AW   = $clog2(NB);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done;
`ifdef IMG_WR_SYNC_CHECK_EN
    logic err;
`endif

    img_frame_writer_if #(.ADDR_W(AW)) bus ();

    img_frame_writer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
`ifdef IMG_WR_SYNC_CHECK_EN
        ,
        .err   (err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int overlap = 0;
    int img[NB];
    logic [23:0] pix[NPIX];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.mem_we === 1'b1) begin
            wr_addr.push_back(int'(bus.mem_addr));
            wr_data.push_back(int'(bus.mem_wdata));
            wr_cyc.push_back(cyc);
            if (int'(bus.mem_addr) < NB) img[bus.mem_addr] = int'(bus.mem_wdata);
            if (bus.s_ready === 1'b1) overlap = overlap + 1;
        end
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    // Reference placement: raster pixel k lands in row slot H-1-row, byte b of its triple.
    function automatic int exp_addr(int k, int b);
        return W * 3 * (H - 1 - k / W) + 3 * (k % W) + b;
    endfunction

    function automatic int exp_byte(int k, int b);
        logic [23:0] p;
        p = pix[k];
        return int'((p >> (8 * (2 - b))) & 24'hFF);
    endfunction

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cnt = 0;
        overlap = 0;
        for (int i = 0; i < NB; i++) img[i] = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        bus.s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drive(input int k0, input int n, input int pct, input int start_at,
                         input int bad_eol, output bit to);
        int k = k0;
        int guard = 0;
        bit hs;
        bit started = 0;
        while (k < n && guard < 3000) begin
            bus.s_data  = pix[k];
            bus.s_valid = ($urandom_range(0, 99) < pct);
`ifdef IMG_WR_SYNC_CHECK_EN
            bus.s_sof = (k == 0);
            bus.s_eol = ((k % W) == W - 1) ^ (k == bad_eol);
`endif
            if (k == start_at && !started) begin
                start = 1'b1;
                started = 1;
            end
            @(negedge clk);
            hs = bus.s_valid && bus.s_ready;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (hs) k++;
            guard++;
        end
        bus.s_valid = 1'b0;
        bus.s_data  = $urandom;
        to = (k < n);
    endtask

    task automatic wait_done(output bit to);
        int guard = 0;
        while (done_cnt == 0 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        to = (done_cnt == 0);
    endtask

    task automatic test_reset();
        logic [AW+12:0] outs;
        rst_n = 1'b0;
        start = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data = 24'h123456;
        @(posedge clk);
        @(negedge clk);
        outs = {bus.s_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, busy, done};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", outs);
        end
`ifdef IMG_WR_SYNC_CHECK_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b want 0", err);
        end
`endif
        start = 1'b0;
        #1 rst_n = 1'b1;
        clear_mon();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (bus.s_ready !== 1'b0 || wr_addr.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_handshake ready %b writes %0d busy %b want 0 0 0",
                     bus.s_ready, wr_addr.size(), busy);
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic test_first_write();
        int exp_a[3] = '{12, 13, 14};
        int exp_d[3] = '{8'hAA, 8'hBB, 8'hCC};
        clear_mon();
        bus.s_data = 24'hAABBCC;
        bus.s_valid = 1'b1;
        pulse_start();
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (wr_addr.size() < 3) begin
            errors++;
            $display("FAIL first_write_count got %0d want >=3", wr_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_addr[i] != exp_a[i] || wr_data[i] != exp_d[i] || wr_cyc[i] != wr_cyc[0] + i) begin
                    errors++;
                    $display("FAIL first_write_%0d got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d",
                             i, wr_addr[i], wr_data[i], wr_cyc[i], exp_a[i], exp_d[i], wr_cyc[0] + i);
                end
            end
        end
        checks++;
        if (overlap != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_write_ready_busy overlap %0d busy %b want 0 1", overlap, busy);
        end
        do_reset();
    endtask

    task automatic test_full_frame();
        bit to, to2;
        for (int k = 0; k < NPIX; k++) pix[k] = {8'(k), 8'(k + 8'h10), 8'(k + 8'h20)};
        clear_mon();
        pulse_start();
        drive(0, NPIX, 100, -1, -1, to);
        wait_done(to2);
        checks++;
        if (to || to2 || wr_addr.size() != NB) begin
            errors++;
            $display("FAIL full_frame_progress timeout %b/%b writes %0d want 0/0 %0d", to, to2, wr_addr.size(), NB);
        end
        for (int i = 0; i < NB && i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[i] != exp_addr(i / 3, i % 3) || wr_data[i] != exp_byte(i / 3, i % 3)) begin
                errors++;
                $display("FAIL full_frame_write_%0d got a=%0d d=%h want a=%0d d=%h", i, wr_addr[i],
                         wr_data[i], exp_addr(i / 3, i % 3), exp_byte(i / 3, i % 3));
            end
        end
        checks++;
        if (wr_cyc.size() == NB && (done_cnt != 1 || done_cyc != wr_cyc[NB-1] + 1)) begin
            errors++;
            $display("FAIL full_frame_done count %0d cyc %0d want 1 %0d", done_cnt, done_cyc, wr_cyc[NB-1] + 1);
        end
        checks++;
        if (busy !== 1'b0 || overlap != 0) begin
            errors++;
            $display("FAIL full_frame_end busy %b overlap %0d want 0 0", busy, overlap);
        end
    endtask

    task automatic test_random_valid();
        bit to, to2;
        int bad = 0;
        for (int k = 0; k < NPIX; k++) pix[k] = 24'($urandom);
        clear_mon();
        pulse_start();
        drive(0, NPIX, 40, -1, -1, to);
        wait_done(to2);
        for (int k = 0; k < NPIX; k++)
            for (int b = 0; b < 3; b++)
                if (img[exp_addr(k, b)] != exp_byte(k, b)) bad++;
        checks++;
        if (to || to2 || bad != 0 || wr_addr.size() != NB || done_cnt != 1) begin
            errors++;
            $display("FAIL random_valid timeout %b/%b bad_bytes %0d writes %0d dones %0d want 0/0 0 %0d 1",
                     to, to2, bad, wr_addr.size(), done_cnt, NB);
        end
    endtask

    task automatic test_start_while_busy();
        bit to, to2;
        int bad = 0;
        for (int k = 0; k < NPIX; k++) pix[k] = 24'($urandom);
        clear_mon();
        pulse_start();
        drive(0, NPIX, 70, 3, -1, to);
        wait_done(to2);
        for (int i = 0; i < NB && i < wr_addr.size(); i++)
            if (wr_addr[i] != exp_addr(i / 3, i % 3) || wr_data[i] != exp_byte(i / 3, i % 3)) bad++;
        checks++;
        if (to || to2 || bad != 0 || wr_addr.size() != NB || done_cnt != 1) begin
            errors++;
            $display("FAIL start_while_busy timeout %b/%b bad %0d writes %0d dones %0d want 0/0 0 %0d 1",
                     to, to2, bad, wr_addr.size(), done_cnt, NB);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit to, to2;
        int bad = 0;
        logic [AW+12:0] outs;
        for (int k = 0; k < NPIX; k++) pix[k] = 24'($urandom);
        clear_mon();
        pulse_start();
        drive(0, 3, 100, -1, -1, to);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        outs = {bus.s_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, busy, done};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %h want 0", outs);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_no_done dones %0d busy %b want 0 0", done_cnt, busy);
        end
        for (int k = 0; k < NPIX; k++) pix[k] = 24'($urandom);
        clear_mon();
        pulse_start();
        drive(0, NPIX, 60, -1, -1, to);
        wait_done(to2);
        for (int k = 0; k < NPIX; k++)
            for (int b = 0; b < 3; b++)
                if (img[exp_addr(k, b)] != exp_byte(k, b)) bad++;
        checks++;
        if (to || to2 || wr_addr.size() != NB || wr_addr[0] != 12 || bad != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL mid_reset_new_frame timeout %b/%b writes %0d first %0d bad %0d dones %0d want 0/0 %0d 12 0 1",
                     to, to2, wr_addr.size(), wr_addr.size() > 0 ? wr_addr[0] : -1, bad, done_cnt, NB);
        end
    endtask

`ifdef IMG_WR_SYNC_CHECK_EN
    task automatic test_sync_err();
        bit to, to2;
        for (int k = 0; k < NPIX; k++) pix[k] = 24'($urandom);
        clear_mon();
        pulse_start();
        drive(0, 2, 100, -1, 2, to);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL sync_err_early got %b want 0", err);
        end
        drive(2, 3, 100, -1, 2, to);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL sync_err_rise got %b want 1", err);
        end
        drive(3, NPIX, 100, -1, 2, to);
        wait_done(to2);
        checks++;
        if (err !== 1'b1 || done_cnt != 1) begin
            errors++;
            $display("FAIL sync_err_sticky err %b dones %0d want 1 1", err, done_cnt);
        end
        clear_mon();
        pulse_start();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL sync_err_clear got %b want 0", err);
        end
        drive(0, NPIX, 100, -1, -1, to);
        wait_done(to2);
        checks++;
        if (err !== 1'b0 || done_cnt != 1) begin
            errors++;
            $display("FAIL sync_err_clean_frame err %b dones %0d want 0 1", err, done_cnt);
        end
    endtask
`endif

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data = '0;
`ifdef IMG_WR_SYNC_CHECK_EN
        bus.s_sof = 1'b0;
        bus.s_eol = 1'b0;
`endif
        @(posedge clk);
        #1;
        test_reset();
        test_first_write();
        test_full_frame();
        test_random_valid();
        test_start_while_busy();
        test_reset_mid_frame();
`ifdef IMG_WR_SYNC_CHECK_EN
        test_sync_err();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
